keypad_scan: RTL and testbench

Matrix keypad scanner for the board's 4x4 key matrix. It is the input-side counterpart to the multiplexed seven-segment display driver: it drives one column at a time, reads the row lines back, and debounces the result. It emits a one-cycle key event carrying a 4-bit key code, plus a held flag. The controller uses these outputs alongside or in place of the discrete push-button inputs.

---
 rtl/keypad_scan_pkg.sv | 56 +++++
 rtl/row_sync.sv | 24 ++
 rtl/keypad_scan.sv | 145 ++++++++++++++
 tb/tb_keypad_scan.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared encodings, sizes and small helpers for the 4x4 keypad scanner.
package keypad_scan_pkg;

  localparam int N_COL = 4;
  localparam int N_ROW = 4;
  localparam int KEY_W = 4;

  // Column drive is active-low, so the idle/reset pattern drives column 0.
  localparam logic [N_COL-1:0] COL_IDLE = 4'b1110;

  // Rows are pulled up; all ones means nothing is pressed in the driven column.
  localparam logic [N_ROW-1:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Index of the lowest row pulled low; the lowest row wins when several are pressed.
  function automatic logic [1:0] lowest_row(input logic [N_ROW-1:0] pattern);
    logic [1:0] idx;
    idx = 2'd0;
    if (!pattern[0]) begin
      idx = 2'd0;
    end else if (!pattern[1]) begin
      idx = 2'd1;
    end else if (!pattern[2]) begin
      idx = 2'd2;
    end else if (!pattern[3]) begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [N_COL-1:0] col_drive(input logic [1:0] col);
    logic [N_COL-1:0] drive;
    drive      = '1;
    drive[col] = 1'b0;
    return drive;
  endfunction

  // Increment that sticks at the limit so the match counter never wraps.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] limit);
    logic [7:0] nxt;
    if (cnt >= limit) begin
      nxt = limit;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/row_sync.sv
// row_sync: two-flop synchronizer for the asynchronous, pulled-up row sense lines.
module row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Resets to all ones so a reset never looks like a key press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: drives one keypad column at a time, debounces the rows read back
// and reports a single key event per press/release pair plus a held flag.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter logic [31:0] SCAN_DIV     = 32'd50000,
  parameter logic [7:0]  DEBOUNCE_CNT = 8'd4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [N_COL-1:0] o_col_enb,
  input  logic [N_ROW-1:0] i_row,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_held
);

  logic [N_ROW-1:0] row_s;
  logic [31:0]      dwell;
  logic             sample;
  scan_state_t      state;
  logic [1:0]       col;
  logic [1:0]       next_col;
  logic [N_ROW-1:0] pattern;
  logic [7:0]       count;
  logic [7:0]       count_inc;
  logic             rows_idle;
  logic             accept;
  logic             release_done;

  row_sync #(
    .WIDTH(N_ROW)
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .d  (i_row),
    .q  (row_s)
  );

  assign sample    = (dwell == (SCAN_DIV - 32'd1));
  assign rows_idle = (row_s == ROW_IDLE);
  assign next_col  = col + 2'd1;
  assign count_inc = sat_inc(count, DEBOUNCE_CNT);

  // Dwell counter: gives the rows SCAN_DIV-1 cycles to settle before each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= 32'd0;
    end else if (sample) begin
      dwell <= 32'd0;
    end else begin
      dwell <= dwell + 32'd1;
    end
  end

  // Decode the two sample-point outcomes that change the outputs: accepting a press and completing a release.
  always_comb begin
    accept       = 1'b0;
    release_done = 1'b0;
    if (sample) begin
      unique case (state)
        SCAN: begin
          accept = !rows_idle && (DEBOUNCE_CNT <= 8'd1);
        end
        DEBOUNCE: begin
          accept = (row_s == pattern) && (count_inc >= DEBOUNCE_CNT);
        end
        HELD: begin
          release_done = rows_idle && (DEBOUNCE_CNT <= 8'd1);
        end
        RELEASE: begin
          release_done = rows_idle && (count_inc >= DEBOUNCE_CNT);
        end
      endcase
    end
  end

  // Scan/debounce state machine; the column stays frozen from first detection until the release is debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCAN;
      col         <= 2'd0;
      pattern     <= ROW_IDLE;
      count       <= 8'd0;
      o_col_enb   <= COL_IDLE;
      o_key_code  <= '0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (accept) begin
        pattern     <= row_s;
        count       <= 8'd0;
        o_key_code  <= {lowest_row(row_s), col};
        o_key_valid <= 1'b1;
        o_key_held  <= 1'b1;
        state       <= HELD;
      end else if (release_done) begin
        count      <= 8'd0;
        o_key_held <= 1'b0;
        col        <= next_col;
        o_col_enb  <= col_drive(next_col);
        state      <= SCAN;
      end else if (sample) begin
        unique case (state)
          SCAN: begin
            if (rows_idle) begin
              col       <= next_col;
              o_col_enb <= col_drive(next_col);
            end else begin
              pattern <= row_s;
              count   <= 8'd1;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_s == pattern) begin
              count <= count_inc;
            end else begin
              count     <= 8'd0;
              col       <= next_col;
              o_col_enb <= col_drive(next_col);
              state     <= SCAN;
            end
          end
          HELD: begin
            if (rows_idle) begin
              count <= 8'd1;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (rows_idle) begin
              count <= count_inc;
            end else begin
              count <= 8'd0;
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed and randomized key activity on a modelled 4x4 matrix,
// checked every cycle against a sample-level behavioural model of the scanner.
module tb_keypad_scan;

  localparam logic [31:0] SCAN_DIV     = 32'd4;
  localparam logic [7:0]  DEBOUNCE_CNT = 8'd3;
  localparam int DIV = 4;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  o_col_enb;
  logic [3:0]  i_row;
  logic [3:0]  o_key_code;
  logic        o_key_valid;
  logic        o_key_held;
  logic [15:0] pressed = '0;

  int n_compared   = 0;
  int n_mismatched = 0;
  int pulse_count  = 0;

  // Model of the scanner, expressed as runs of identical samples per column.
  int         m_cyc;
  int         m_col;
  int         m_run;
  bit         m_frozen;
  bit         m_held;
  bit         m_valid;
  logic [3:0] m_pattern;
  logic [3:0] m_code;
  logic [3:0] m_h1;
  logic [3:0] m_h2;

  keypad_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .o_col_enb  (o_col_enb),
    .i_row      (i_row),
    .o_key_code (o_key_code),
    .o_key_valid(o_key_valid),
    .o_key_held (o_key_held)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    i_row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!o_col_enb[2'(c)]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[4'(4 * r + c)]) i_row[2'(r)] = 1'b0;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] key_bit(input int row, input int col);
    logic [15:0] k;
    k = '0;
    k[4'(4 * row + col)] = 1'b1;
    return k;
  endfunction

  function automatic logic [3:0] rows_seen(input logic [15:0] keys, input int col);
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (keys[4'(4 * r + col)]) rows[2'(r)] = 1'b0;
    end
    return rows;
  endfunction

  function automatic logic [3:0] drive_of(input int col);
    logic [3:0] d;
    d = 4'b1111;
    d[2'(col)] = 1'b0;
    return d;
  endfunction

  function automatic int first_low(input logic [3:0] rows);
    for (int r = 0; r < 4; r++) begin
      if (!rows[2'(r)]) return r;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_cyc     = 0;
    m_col     = 0;
    m_run     = 0;
    m_frozen  = 1'b0;
    m_held    = 1'b0;
    m_valid   = 1'b0;
    m_pattern = 4'hF;
    m_code    = 4'h0;
    m_h1      = 4'hF;
    m_h2      = 4'hF;
  endtask

  task automatic model_accept();
    m_code  = 4'(4 * first_low(m_pattern) + m_col);
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_run   = 0;
  endtask

  task automatic model_sample(input logic [3:0] rs);
    if (!m_frozen) begin
      if (rs == 4'hF) begin
        m_col = (m_col + 1) % 4;
      end else begin
        m_frozen  = 1'b1;
        m_pattern = rs;
        m_run     = 1;
        if (m_run >= DEB) model_accept();
      end
    end else if (!m_held) begin
      if (rs == m_pattern) begin
        m_run = m_run + 1;
        if (m_run >= DEB) model_accept();
      end else begin
        m_frozen = 1'b0;
        m_col    = (m_col + 1) % 4;
      end
    end else begin
      if (rs == 4'hF) begin
        m_run = m_run + 1;
        if (m_run >= DEB) begin
          m_held   = 1'b0;
          m_frozen = 1'b0;
          m_run    = 0;
          m_col    = (m_col + 1) % 4;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One clock of the model: the scanner decides on the row value from two clocks earlier.
  task automatic model_step();
    logic [3:0] rs;
    rs      = m_h2;
    m_h2    = m_h1;
    m_h1    = rows_seen(pressed, m_col);
    m_valid = 1'b0;
    if ((m_cyc % DIV) == (DIV - 1)) model_sample(rs);
    m_cyc = m_cyc + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (o_key_valid) pulse_count++;
    checkOutput("col_enb", 32'(o_col_enb), 32'(drive_of(m_col)));
    checkOutput("key_code", 32'(o_key_code), 32'(m_code));
    checkOutput("key_valid", 32'(o_key_valid), 32'(m_valid));
    checkOutput("key_held", 32'(o_key_held), 32'(m_held));
  endtask

  task automatic next_sample();
    do begin
      tick();
    end while (((m_cyc - 1) % DIV) != (DIV - 1));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int waited;
    bit seen;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      seen = o_key_valid;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_released(input string tag, input int budget);
    int waited;
    bit gone;
    waited = 0;
    gone   = !o_key_held;
    while (!gone && waited < budget) begin
      tick();
      waited++;
      gone = !o_key_held;
    end
    checkOutput(tag, 32'(gone), 32'd1);
  endtask

  initial begin
    int p0;
    int hold;
    int nkeys;
    logic [15:0] keys;

    $display("[TB] keypad_scan bench start");
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_col_enb", 32'(o_col_enb), 32'h0000000E);
    checkOutput("reset_key_code", 32'(o_key_code), 32'd0);
    checkOutput("reset_key_valid", 32'(o_key_valid), 32'd0);
    checkOutput("reset_key_held", 32'(o_key_held), 32'd0);
    rst = 1'b0;

    // Idle rotation: one column per SCAN_DIV clocks, in order 0,1,2,3.
    for (int e = 0; e < 16; e++) begin
      tick();
      checkOutput("idle_rotation", 32'(o_col_enb), 32'(drive_of(((e + 1) / DIV) % 4)));
    end
    p0 = pulse_count;
    repeat (1000) tick();
    checkOutput("idle_no_pulse", 32'(pulse_count - p0), 32'd0);

    // Stable press at row 2 / column 1.
    p0 = pulse_count;
    applyStimulus(key_bit(2, 1));
    wait_valid("press_r2c1_timeout", 200);
    checkOutput("press_r2c1_code", 32'(o_key_code), 32'd9);
    checkOutput("press_r2c1_held", 32'(o_key_held), 32'd1);
    checkOutput("press_r2c1_col", 32'(o_col_enb), 32'h0000000D);
    repeat (3) next_sample();
    checkOutput("held_col_frozen", 32'(o_col_enb), 32'h0000000D);
    checkOutput("held_single_pulse", 32'(pulse_count - p0), 32'd1);

    // Release with one bounce back low, then three clean idle samples.
    p0 = pulse_count;
    applyStimulus('0);
    next_sample();
    applyStimulus(key_bit(2, 1));
    next_sample();
    checkOutput("bounce_release_held", 32'(o_key_held), 32'd1);
    applyStimulus('0);
    next_sample();
    next_sample();
    checkOutput("release_partial_held", 32'(o_key_held), 32'd1);
    next_sample();
    checkOutput("release_done_held", 32'(o_key_held), 32'd0);
    checkOutput("release_next_col", 32'(o_col_enb), 32'h0000000B);
    checkOutput("release_no_pulse", 32'(pulse_count - p0), 32'd0);

    // Press at row 0 / column 3 that bounces high at its second sample.
    p0 = pulse_count;
    applyStimulus(key_bit(0, 3));
    next_sample();
    next_sample();
    applyStimulus('0);
    next_sample();
    checkOutput("bounce_press_col_advanced", 32'(o_col_enb), 32'h0000000E);
    checkOutput("bounce_press_no_pulse", 32'(pulse_count - p0), 32'd0);
    applyStimulus(key_bit(0, 3));
    wait_valid("press_r0c3_timeout", 200);
    checkOutput("press_r0c3_code", 32'(o_key_code), 32'd3);
    applyStimulus('0);
    wait_released("release_r0c3_timeout", 200);

    // Rows 0 and 3 together in column 2: lowest row wins.
    p0 = pulse_count;
    applyStimulus(key_bit(0, 2) | key_bit(3, 2));
    wait_valid("press_dual_timeout", 200);
    checkOutput("press_dual_code", 32'(o_key_code), 32'd2);
    repeat (4) next_sample();
    checkOutput("press_dual_single_pulse", 32'(pulse_count - p0), 32'd1);
    applyStimulus('0);
    wait_released("release_dual_timeout", 200);

    // Reset while a key is held, away from any clock edge.
    applyStimulus(key_bit(1, 0));
    wait_valid("press_r1c0_timeout", 200);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("midreset_key_held", 32'(o_key_held), 32'd0);
    checkOutput("midreset_key_code", 32'(o_key_code), 32'd0);
    checkOutput("midreset_col_enb", 32'(o_col_enb), 32'h0000000E);
    checkOutput("midreset_key_valid", 32'(o_key_valid), 32'd0);
    applyStimulus('0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checkOutput("restart_rotation", 32'(o_col_enb), 32'(drive_of(((e + 1) / DIV) % 4)));
    end
    applyStimulus(key_bit(1, 1));
    wait_valid("restart_press_timeout", 200);
    checkOutput("restart_press_code", 32'(o_key_code), 32'd5);
    applyStimulus('0);
    wait_released("restart_release_timeout", 200);

    // Random key activity, including multi-key and short glitches.
    for (int it = 0; it < 60; it++) begin
      keys  = '0;
      nkeys = int'($urandom_range(0, 2));
      for (int k = 0; k < nkeys; k++) begin
        keys[4'($urandom_range(0, 15))] = 1'b1;
      end
      applyStimulus(keys);
      hold = int'($urandom_range(1, 60));
      repeat (hold) tick();
    end
    applyStimulus('0);
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
